// File: rtl/config_chain_segment_pkg.sv
// Shared definitions for the configuration chain segment and its future readback block.
package config_chain_segment_pkg;

  localparam int CFG_ST_W = 2;

  typedef enum logic [CFG_ST_W-1:0] {
    CFG_ST_EMPTY   = 2'd0,
    CFG_ST_LOADING = 2'd1,
    CFG_ST_LOADED  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/config_chain_segment.sv
// One daisy-chained configuration segment: LSB-first deserialiser, shadow commit register,
// registered forwarding to the next segment, and sticky alignment status.
module config_chain_segment
  import config_chain_segment_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cen_i,
  input  logic                 set_i,
  input  logic                 shift_i,
  input  logic                 err_clr_i,
  output logic                 cen_o,
  output logic                 set_o,
  output logic                 shift_o,
  output logic [CHAIN_LEN-1:0] cfg_o,
  output logic                 cfg_valid_o,
  output logic [CNT_W-1:0]     bit_count_o,
  output logic                 misalign_err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] sr, sr_next;
  logic [CNT_W-1:0]     cnt_next;
  logic                 committed;
  cfg_state_e           state, state_next;

  // Commit and alignment check both look at the post-shift view of this cycle.
  always_comb begin
    sr_next  = sr;
    cnt_next = bit_count_o;
    if (cen_i) begin
      sr_next  = {shift_i, sr[CHAIN_LEN-1:1]};
      cnt_next = (bit_count_o == CNT_LAST) ? '0 : bit_count_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CFG_ST_EMPTY: begin
        if (set_i)      state_next = CFG_ST_LOADED;
        else if (cen_i) state_next = CFG_ST_LOADING;
      end
      CFG_ST_LOADING: begin
        if (set_i) state_next = CFG_ST_LOADED;
      end
      CFG_ST_LOADED: begin
        if (cen_i && !set_i) state_next = CFG_ST_LOADING;
      end
      default: state_next = CFG_ST_EMPTY;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sr             <= '0;
      cfg_o          <= '0;
      bit_count_o    <= '0;
      cen_o          <= 1'b0;
      set_o          <= 1'b0;
      shift_o        <= 1'b0;
      committed      <= 1'b0;
      misalign_err_o <= 1'b0;
      state          <= CFG_ST_EMPTY;
    end else begin
      sr          <= sr_next;
      bit_count_o <= cnt_next;
      cen_o       <= cen_i;
      set_o       <= set_i;
      shift_o     <= cen_i ? sr[0] : 1'b0;
      state       <= state_next;
      if (set_i) begin
        cfg_o     <= sr_next;
        committed <= 1'b1;
      end
      // A fresh misaligned commit outranks a simultaneous clear.
      if (set_i && (cnt_next != '0)) misalign_err_o <= 1'b1;
      else if (err_clr_i)            misalign_err_o <= 1'b0;
    end
  end

  assign cfg_valid_o = (state != CFG_ST_EMPTY) || committed;

endmodule

// File: tb/tb_config_chain_segment.sv
// Bench for config_chain_segment: two chained 8-bit segments and one 64-bit segment,
// compared every cycle against a bit-history model of each segment.
module tb_config_chain_segment;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cen_a, set_a, sh_a, clr_a, clr_b;
  logic cen64, set64, sh64, clr64;

  logic       cen_ao, set_ao, sh_ao, val_a, err_a;
  logic [7:0] cfg_a;
  logic [2:0] cnt_a;
  logic       cen_bo, set_bo, sh_bo, val_b, err_b;
  logic [7:0] cfg_b;
  logic [2:0] cnt_b;
  logic        cen_6o, set_6o, sh_6o, val_6, err_6;
  logic [63:0] cfg_6;
  logic [5:0]  cnt_6;

  config_chain_segment #(.CHAIN_LEN(8)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .cen_i(cen_a), .set_i(set_a), .shift_i(sh_a),
    .err_clr_i(clr_a), .cen_o(cen_ao), .set_o(set_ao), .shift_o(sh_ao), .cfg_o(cfg_a),
    .cfg_valid_o(val_a), .bit_count_o(cnt_a), .misalign_err_o(err_a));

  config_chain_segment #(.CHAIN_LEN(8)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .cen_i(cen_ao), .set_i(set_ao), .shift_i(sh_ao),
    .err_clr_i(clr_b), .cen_o(cen_bo), .set_o(set_bo), .shift_o(sh_bo), .cfg_o(cfg_b),
    .cfg_valid_o(val_b), .bit_count_o(cnt_b), .misalign_err_o(err_b));

  config_chain_segment #(.CHAIN_LEN(64)) u_64 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cen_i(cen64), .set_i(set64), .shift_i(sh64),
    .err_clr_i(clr64), .cen_o(cen_6o), .set_o(set_6o), .shift_o(sh_6o), .cfg_o(cfg_6),
    .cfg_valid_o(val_6), .bit_count_o(cnt_6), .misalign_err_o(err_6));

  // Model: every bit ever received (newest last); sr is simply the last N of them.
  bit          hist[3][$];
  int          shifts[3];
  logic [63:0] m_cfg[3];
  bit          m_val[3], m_err[3], m_sh[3], m_c[3], m_s[3];
  int          nlen[3] = '{8, 8, 64};

  int nvec  = 0;
  int nfail = 0;

  function automatic logic [63:0] window(input int k);
    logic [63:0] w;
    int sz;
    w  = '0;
    sz = hist[k].size();
    for (int i = 0; i < nlen[k]; i++)
      if (sz - nlen[k] + i >= 0) w[i] = hist[k][sz - nlen[k] + i];
    return w;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      hist[k].delete();
      shifts[k] = 0;
      m_cfg[k]  = '0;
      m_val[k]  = 0; m_err[k] = 0; m_sh[k] = 0; m_c[k] = 0; m_s[k] = 0;
    end
  endtask

  task automatic mupd(input int k, input bit c, input bit s, input bit b, input bit clr);
    int n, sz;
    bit leave;
    n     = nlen[k];
    sz    = hist[k].size();
    leave = (sz - n >= 0) ? hist[k][sz - n] : 1'b0;
    m_c[k]  = c;
    m_s[k]  = s;
    m_sh[k] = c ? leave : 1'b0;
    if (c) begin
      hist[k].push_back(b);
      shifts[k]++;
      if (hist[k].size() > 70) void'(hist[k].pop_front());
    end
    if (s) m_cfg[k] = window(k);
    if (s && (shifts[k] % n != 0)) m_err[k] = 1;
    else if (clr)                  m_err[k] = 0;
    if (c || s) m_val[k] = 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_cfg",   64'(cfg_a),  m_cfg[0]);
    chk("a_cnt",   64'(cnt_a),  64'(shifts[0] % 8));
    chk("a_err",   64'(err_a),  64'(m_err[0]));
    chk("a_valid", 64'(val_a),  64'(m_val[0]));
    chk("a_sho",   64'(sh_ao),  64'(m_sh[0]));
    chk("a_ceno",  64'(cen_ao), 64'(m_c[0]));
    chk("a_seto",  64'(set_ao), 64'(m_s[0]));
    chk("b_cfg",   64'(cfg_b),  m_cfg[1]);
    chk("b_cnt",   64'(cnt_b),  64'(shifts[1] % 8));
    chk("b_err",   64'(err_b),  64'(m_err[1]));
    chk("b_valid", 64'(val_b),  64'(m_val[1]));
    chk("b_sho",   64'(sh_bo),  64'(m_sh[1]));
    chk("b_ceno",  64'(cen_bo), 64'(m_c[1]));
    chk("b_seto",  64'(set_bo), 64'(m_s[1]));
    chk("w_cfg",   cfg_6,       m_cfg[2]);
    chk("w_cnt",   64'(cnt_6),  64'(shifts[2] % 64));
    chk("w_err",   64'(err_6),  64'(m_err[2]));
    chk("w_valid", 64'(val_6),  64'(m_val[2]));
    chk("w_sho",   64'(sh_6o),  64'(m_sh[2]));
    chk("w_ceno",  64'(cen_6o), 64'(m_c[2]));
    chk("w_seto",  64'(set_6o), 64'(m_s[2]));
  endtask

  // Segment b sees segment a's registered outputs from before this edge.
  task automatic tick();
    bit bc, bs, bb;
    @(posedge clk);
    if (rst) mreset();
    else begin
      bc = m_c[0]; bs = m_s[0]; bb = m_sh[0];
      mupd(1, bc, bs, bb, clr_b);
      mupd(0, cen_a, set_a, sh_a, clr_a);
      mupd(2, cen64, set64, sh64, clr64);
    end
    #1 check_all();
  endtask

  task automatic idle();
    cen_a = 0; set_a = 0; sh_a = 0; clr_a = 0; clr_b = 0;
    cen64 = 0; set64 = 0; sh64 = 0; clr64 = 0;
  endtask

  task automatic load_a(input logic [15:0] v, input int nbits, input int set_at);
    for (int i = 0; i < nbits; i++) begin
      cen_a = 1; sh_a = v[i]; set_a = (i == set_at);
      tick();
    end
    idle();
  endtask

  initial begin
    logic [7:0] bv;
    mreset();
    idle();

    // Reset wins over arbitrary input activity
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      {cen_a, set_a, sh_a, clr_a, clr_b} = 5'($urandom);
      {cen64, set64, sh64, clr64}        = 4'($urandom);
      tick();
    end
    chk("rst_cfg64", cfg_6, 64'h0);
    chk("rst_valid", 64'(val_a), 64'h0);
    rst = 0;
    idle();
    tick();

    // 0xA5 into the 8-bit segment, commit on the 8th bit
    load_a(16'h00A5, 8, 7);
    chk("a5_cfg",   64'(cfg_a), 64'hA5);
    chk("a5_valid", 64'(val_a), 64'h1);
    chk("a5_cnt",   64'(cnt_a), 64'h0);
    chk("a5_err",   64'(err_a), 64'h0);

    // Eight bytes 0x01..0x08 into the 64-bit segment
    for (int bt = 1; bt <= 8; bt++) begin
      bv = 8'(bt);
      for (int i = 0; i < 8; i++) begin
        cen64 = 1; sh64 = bv[i]; set64 = (bt == 8 && i == 7);
        tick();
      end
    end
    idle();
    tick();
    chk("w_cfg_bytes", cfg_6, 64'h0807060504030201);

    // Random refill: shift_o must replay the prior contents
    for (int i = 0; i < 64; i++) begin
      cen64 = 1; sh64 = 1'($urandom); set64 = (i == 63);
      tick();
    end
    idle();
    tick();

    // Misaligned commit, clear, then clear racing a new misaligned commit
    load_a(16'h0015, 5, 4);
    chk("mis_err", 64'(err_a), 64'h1);
    clr_a = 1; tick(); idle();
    chk("clr_err", 64'(err_a), 64'h0);
    for (int i = 0; i < 5; i++) begin
      cen_a = 1; sh_a = 1'($urandom); set_a = (i == 4); clr_a = (i == 4);
      tick();
    end
    idle();
    chk("race_err", 64'(err_a), 64'h1);

    // Free-run zeros after a clean commit of 0xA5
    rst = 1; tick(); rst = 0;
    load_a(16'h00A5, 8, 7);
    for (int i = 0; i < 100; i++) begin
      cen_a = 1; sh_a = 0;
      tick();
    end
    idle();
    tick();
    chk("fr_cfg", 64'(cfg_a), 64'hA5);
    chk("fr_cnt", 64'(cnt_a), 64'h4);

    // Two chained segments: 0x3C then 0xC3
    rst = 1; tick(); rst = 0;
    idle();
    load_a(16'hC33C, 16, 15);
    chk("ch_a_cfg", 64'(cfg_a), 64'hC3);
    tick();
    chk("ch_b_cfg", 64'(cfg_b), 64'h3C);

    // Random traffic on all lanes
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(63) == 0);
      cen_a = 1'($urandom); sh_a = 1'($urandom);
      set_a = ($urandom_range(7) == 0);
      clr_a = ($urandom_range(5) == 0); clr_b = ($urandom_range(5) == 0);
      cen64 = 1'($urandom); sh64 = 1'($urandom);
      set64 = ($urandom_range(15) == 0); clr64 = ($urandom_range(5) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
